// File: rtl/sgmii_an_fsm.sv
// rtl/sgmii_an_fsm.sv - SGMII/1000BASE-X clause-37-style auto-negotiation engine
module sgmii_an_fsm #(
    parameter logic [15:0] LOCAL_CFG   = 16'h0001,
    parameter int          LINK_TIMER  = 200000,
    parameter int          MATCH_COUNT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_is_k,
    input  logic        rx_sync,
    input  logic        an_restart_config,
    output logic [1:0]  tx_mode,
    output logic [15:0] tx_cfg,
    output logic [15:0] partner_cfg,
    output logic [15:0] eth_status
);

    localparam logic [2:0] AN_RESTART     = 3'd0;
    localparam logic [2:0] ABILITY_DETECT = 3'd1;
    localparam logic [2:0] ACK_DETECT     = 3'd2;
    localparam logic [2:0] COMPLETE_ACK   = 3'd3;
    localparam logic [2:0] IDLE_DETECT    = 3'd4;
    localparam logic [2:0] LINK_OK        = 3'd5;

    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_K    = 2'd1;
    localparam logic [1:0] P_LO   = 2'd2;
    localparam logic [1:0] P_HI   = 2'd3;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    localparam int TW = $clog2(LINK_TIMER + 1);
    localparam int CW = $clog2(MATCH_COUNT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMER - 1);
    localparam logic [TW-1:0] TIMER_END  = TW'(LINK_TIMER);
    localparam logic [CW-1:0] MATCH      = CW'(MATCH_COUNT);

    localparam logic [15:0] CFG_NO_ACK = {LOCAL_CFG[15], 1'b0, LOCAL_CFG[13:0]};
    localparam logic [15:0] CFG_ACK    = {LOCAL_CFG[15], 1'b1, LOCAL_CFG[13:0]};

    logic [1:0]    p_phase;
    logic [7:0]    cfg_lo;
    logic [15:0]   cfg_word;
    logic          cfg_strobe;
    logic          idle_strobe;

    logic [15:0]   last_word;
    logic [CW-1:0] abil_cnt;
    logic [CW-1:0] ack_cnt;
    logic [CW-1:0] idle_cnt;
    logic          same_word;
    logic          ability_match;
    logic          ack_match;
    logic          idle_match;
    logic          match_zero;

    logic [TW-1:0] timer;
    logic          timer_done;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [13:0]   stored_word;
    logic          store_word;
    logic          latch_partner;
    logic          restart_q;
    logic          restart_edge;
    logic          force_restart;
    logic          entry;
    logic          cfg_seen;
    logic          seen_next;
    logic [15:0]   partner_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= MATCH) ? MATCH : c + 1'b1;
    endfunction

    // Ordered-set parser: K28.5 then either a config marker (+lo,+hi) or an idle marker.
    always_ff @(posedge clock) begin
        cfg_strobe  <= 1'b0;
        idle_strobe <= 1'b0;
        if (reset || !rx_sync) begin
            p_phase <= P_HUNT;
        end else if (rx_valid) begin
            case (p_phase)
                P_HUNT: if (rx_is_k && rx_data == K28_5) p_phase <= P_K;
                P_K: begin
                    p_phase <= P_HUNT;
                    if (!rx_is_k && (rx_data == D21_5 || rx_data == D2_2))
                        p_phase <= P_LO;
                    else if (!rx_is_k && (rx_data == D5_6 || rx_data == D16_2))
                        idle_strobe <= 1'b1;
                end
                P_LO: begin
                    if (rx_is_k) begin
                        p_phase <= P_HUNT;
                    end else begin
                        cfg_lo  <= rx_data;
                        p_phase <= P_HI;
                    end
                end
                default: begin
                    p_phase <= P_HUNT;
                    if (!rx_is_k) begin
                        cfg_word   <= {rx_data, cfg_lo};
                        cfg_strobe <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign same_word     = ({cfg_word[15], cfg_word[13:0]} == {last_word[15], last_word[13:0]});
    assign ability_match = (abil_cnt == MATCH);
    assign ack_match     = (ack_cnt == MATCH);
    assign idle_match    = (idle_cnt == MATCH);
    assign match_zero    = ({last_word[15], last_word[13:0]} == 15'd0);

    // Match history restarts on every state entry so a match left over from the
    // previous state can never fire a transition in the new one.
    always_ff @(posedge clock) begin
        if (reset || entry) begin
            abil_cnt  <= '0;
            ack_cnt   <= '0;
            idle_cnt  <= '0;
            last_word <= '0;
        end else if (cfg_strobe) begin
            idle_cnt  <= '0;
            last_word <= cfg_word;
            if (abil_cnt != '0 && same_word) begin
                abil_cnt <= sat_inc(abil_cnt);
                ack_cnt  <= cfg_word[14] ? sat_inc(ack_cnt) : '0;
            end else begin
                abil_cnt <= CW'(1);
                ack_cnt  <= cfg_word[14] ? CW'(1) : '0;
            end
        end else if (idle_strobe) begin
            abil_cnt <= '0;
            ack_cnt  <= '0;
            idle_cnt <= sat_inc(idle_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || entry)
            timer <= '0;
        else if (timer != TIMER_END)
            timer <= timer + 1'b1;
    end

    assign timer_done = (timer >= TIMER_LAST);

    always_ff @(posedge clock) begin
        restart_q <= an_restart_config;
    end

    assign restart_edge  = an_restart_config && !restart_q && !reset;
    assign force_restart = !rx_sync || restart_edge;
    assign entry         = (next_state != state) || force_restart;

    always_comb begin
        next_state    = state;
        store_word    = 1'b0;
        latch_partner = 1'b0;
        case (state)
            AN_RESTART:
                if (timer_done) next_state = ABILITY_DETECT;
            ABILITY_DETECT:
                if (ability_match && !match_zero) begin
                    next_state = ACK_DETECT;
                    store_word = 1'b1;
                end
            ACK_DETECT:
                if (ack_match && last_word[13:0] == stored_word) begin
                    next_state    = COMPLETE_ACK;
                    latch_partner = 1'b1;
                end else if ((ability_match && match_zero) || ack_match) begin
                    next_state = AN_RESTART;
                end
            COMPLETE_ACK:
                if (ability_match && match_zero) next_state = AN_RESTART;
                else if (timer_done)             next_state = IDLE_DETECT;
            IDLE_DETECT:
                if (ability_match)                   next_state = AN_RESTART;
                else if (timer_done && idle_match)   next_state = LINK_OK;
            LINK_OK:
                if (ability_match) next_state = AN_RESTART;
            default:
                next_state = AN_RESTART;
        endcase
        if (force_restart) begin
            next_state    = AN_RESTART;
            store_word    = 1'b0;
            latch_partner = 1'b0;
        end
    end

    always_comb begin
        partner_next = latch_partner ? {last_word[15], 1'b0, last_word[13:0]} : partner_cfg;
        seen_next    = (entry && next_state == AN_RESTART) ? 1'b0 : (cfg_seen | cfg_strobe);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= AN_RESTART;
            stored_word <= '0;
            cfg_seen    <= 1'b0;
            partner_cfg <= '0;
            tx_mode     <= 2'b01;
            tx_cfg      <= '0;
            eth_status  <= '0;
        end else begin
            state       <= next_state;
            cfg_seen    <= seen_next;
            partner_cfg <= partner_next;
            if (store_word) stored_word <= last_word[13:0];
            tx_mode <= (next_state == IDLE_DETECT || next_state == LINK_OK) ? 2'b00 : 2'b01;
            tx_cfg  <= (next_state == AN_RESTART)     ? 16'h0000 :
                       (next_state == ABILITY_DETECT) ? CFG_NO_ACK : CFG_ACK;
            eth_status <= {6'b0, partner_next[15], partner_next[12], partner_next[11:10],
                           seen_next, next_state, rx_sync, next_state == LINK_OK};
        end
    end

endmodule
